// File: rtl/fib_seq_engine_if.sv
// Handshake and data bundle between the host request logic and fib_seq_engine.
// master = host side (drives request and seeds), slave = engine side.
interface fib_seq_engine_if #(
    parameter int WIDTH  = 8,
    parameter int NWIDTH = 8
);
    logic              start;
    logic              abort;
    logic [NWIDTH-1:0] n;
    logic [WIDTH-1:0]  seed0;
    logic [WIDTH-1:0]  seed1;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              ovf;

    modport master (
        output start, abort, n, seed0, seed1,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, abort, n, seed0, seed1,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/fib_seq_engine.sv
// Iterative two-term recurrence engine: X(k)=X(k-1)+X(k-2), one add per cycle, sticky overflow.
// Optional macro FIB_SAT_EN: clamp carrying sums to all-ones instead of wrapping.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; seeds and n latched on start
// RUN   | stepping a<=b, b<=a+b until cnt reaches zero (or abort)
// DONE  | one-cycle done pulse, result/ovf just updated
module fib_seq_engine #(
    parameter int WIDTH  = 8,
    parameter int NWIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fib_seq_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [NWIDTH-1:0] cnt_q, cnt_d;
    logic              fa_q, fa_d;
    logic              fb_q, fb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH:0]    sum_full;
    logic [WIDTH-1:0]  sum;
    logic              carry;

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};
    assign carry    = sum_full[WIDTH];
`ifdef FIB_SAT_EN
    assign sum      = carry ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    assign sum      = sum_full[WIDTH-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.seed0;
                    b_d     = bus.seed1;
                    cnt_d   = bus.n;
                    fa_d    = 1'b0;
                    fb_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    result_d = a_q;
                    ovf_d    = fa_q;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    // The flag travels with its value; b's flag only matters once it shifts into a.
                    a_d   = b_q;
                    fa_d  = fb_q;
                    b_d   = sum;
                    fb_d  = fa_q | fb_q | carry;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            fa_q     <= 1'b0;
            fb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

endmodule
